ap_mult_err_eval: RTL and testbench

Sequential exhaustive error evaluator for the approximate unsigned W x W Wallace multipliers built from the ap_com compressor cells.
- Drives every operand pair into an external approximate multiplier and reads back its product.
- Computes the exact product internally and accumulates error metrics: error count, sum of absolute error, maximum absolute error, and the first pair that hit the maximum.
- Sits beside the multiplier under test in characterization builds; it is the consuming end of the multiplier's operand/product interface.

---
 rtl/ap_mult_err_eval.sv | 148 ++++++++++++++
 tb/tb_ap_mult_err_eval.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ap_mult_err_eval.sv
// Exhaustive error evaluator for approximate W x W multipliers.
// Sweeps every operand pair and accumulates error metrics.
module ap_mult_err_eval #(
  parameter int W       = 4,
  parameter int DUT_LAT = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  output logic [W-1:0]   op_a,
  output logic [W-1:0]   op_b,
  input  logic [2*W-1:0] approx_p,
  output logic           busy,
  output logic           done,
  output logic [2*W:0]   err_cnt,
  output logic [4*W:0]   sum_abs_err,
  output logic [2*W-1:0] max_abs_err,
  output logic [W-1:0]   worst_a,
  output logic [W-1:0]   worst_b
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int DW = (DUT_LAT > 1) ? $clog2(DUT_LAT) : 1;
  localparam logic [2*W-1:0] LAST = '1;

  state_t state, state_nx;
  logic [2*W-1:0] cnt;
  logic [DW-1:0]  dcnt;
  logic [2*W-1:0] exact;
  logic [2*W-1:0] abs_err;
  logic           vin;
  logic           vld_d;
  logic [2*W-1:0] ex_d;
  logic [W-1:0]   a_d;
  logic [W-1:0]   b_d;
  logic           clr;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (start) state_nx = RUN;
      RUN:   if (cnt == LAST)
               state_nx = (DUT_LAT > 0) ? DRAIN : DONE;
      DRAIN: if (dcnt == DW'(DUT_LAT - 1)) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN, DRAIN: busy = 1'b1;
      DONE:       done = 1'b1;
      default:    ;
    endcase
  end

  assign clr = (state == IDLE) && start;
  assign vin = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      dcnt <= '0;
    end else begin
      if (clr)
        cnt <= '0;
      else if (state == RUN && cnt != LAST)
        cnt <= cnt + 1'b1;
      if (state == DRAIN) dcnt <= dcnt + 1'b1;
      else                dcnt <= '0;
    end
  end

  // {op_a, op_b} is the pair counter, op_b is the fast index
  assign op_a  = cnt[2*W-1:W];
  assign op_b  = cnt[W-1:0];
  assign exact = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};

  generate
    if (DUT_LAT > 0) begin : g_dly
      logic [DUT_LAT-1:0]          vld_r;
      logic [DUT_LAT-1:0][2*W-1:0] ex_r;
      logic [DUT_LAT-1:0][W-1:0]   a_r;
      logic [DUT_LAT-1:0][W-1:0]   b_r;

      always_ff @(posedge clk) begin
        if (rst) begin
          vld_r <= '0;
        end else begin
          vld_r[0] <= vin;
          for (int j = 1; j < DUT_LAT; j++)
            vld_r[j] <= vld_r[j-1];
        end
        ex_r[0] <= exact;
        a_r[0]  <= op_a;
        b_r[0]  <= op_b;
        for (int j = 1; j < DUT_LAT; j++) begin
          ex_r[j] <= ex_r[j-1];
          a_r[j]  <= a_r[j-1];
          b_r[j]  <= b_r[j-1];
        end
      end

      assign vld_d = vld_r[DUT_LAT-1];
      assign ex_d  = ex_r[DUT_LAT-1];
      assign a_d   = a_r[DUT_LAT-1];
      assign b_d   = b_r[DUT_LAT-1];
    end else begin : g_comb
      assign vld_d = vin;
      assign ex_d  = exact;
      assign a_d   = op_a;
      assign b_d   = op_b;
    end
  endgenerate

  assign abs_err = (approx_p >= ex_d) ? approx_p - ex_d
                                      : ex_d - approx_p;

  // strict greater-than keeps the earliest pair on ties
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_cnt     <= '0;
      sum_abs_err <= '0;
      max_abs_err <= '0;
      worst_a     <= '0;
      worst_b     <= '0;
    end else if (vld_d) begin
      if (abs_err != '0)
        err_cnt <= err_cnt + (2*W+1)'(1);
      sum_abs_err <= sum_abs_err + {{(2*W+1){1'b0}}, abs_err};
      if (abs_err > max_abs_err) begin
        max_abs_err <= abs_err;
        worst_a     <= a_d;
        worst_b     <= b_d;
      end
    end
  end

endmodule

// File: tb/tb_ap_mult_err_eval.sv
// Bench for ap_mult_err_eval: combinational and 2-cycle multiplier models,
// scoreboarded sweep results, reset abort and held-start cases.
module tb_ap_mult_err_eval;

  localparam int W = 4;

  typedef struct {
    int     err;
    longint sum;
    int     mx;
    int     wa;
    int     wb;
    int     dc;
    int     bc;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start0, start2;
  logic [W-1:0]   a0, b0, a2, b2;
  logic [2*W-1:0] ap0, ap2;
  logic           busy0, done0, busy2, done2;
  logic [2*W:0]   ec0, ec2;
  logic [4*W:0]   se0, se2;
  logic [2*W-1:0] mx0, mx2;
  logic [W-1:0]   wa0, wb0, wa2, wb2;

  logic [2*W-1:0] p2_r1, p2_r2;
  int             mode;
  bit             which;

  logic           s_busy, s_done;
  logic [W-1:0]   s_a, s_b, s_wa, s_wb;
  logic [2*W:0]   s_ec;
  logic [4*W:0]   s_se;
  logic [2*W-1:0] s_mx;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sbq[$];

  always #5 clk = ~clk;

  ap_mult_err_eval #(.W(W), .DUT_LAT(0)) u0 (
    .clk(clk), .rst(rst), .start(start0),
    .op_a(a0), .op_b(b0), .approx_p(ap0),
    .busy(busy0), .done(done0),
    .err_cnt(ec0), .sum_abs_err(se0), .max_abs_err(mx0),
    .worst_a(wa0), .worst_b(wb0)
  );

  ap_mult_err_eval #(.W(W), .DUT_LAT(2)) u2 (
    .clk(clk), .rst(rst), .start(start2),
    .op_a(a2), .op_b(b2), .approx_p(ap2),
    .busy(busy2), .done(done2),
    .err_cnt(ec2), .sum_abs_err(se2), .max_abs_err(mx2),
    .worst_a(wa2), .worst_b(wb2)
  );

  always_comb begin
    ap0 = {{W{1'b0}}, a0} * {{W{1'b0}}, b0};
    case (mode)
      1:       ap0 = '0;
      2:       ap0 = ap0 | 8'd1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    p2_r1 <= {{W{1'b0}}, a2} * {{W{1'b0}}, b2};
    p2_r2 <= p2_r1;
  end
  assign ap2 = p2_r2;

  always_comb begin
    s_busy = which ? busy2 : busy0;
    s_done = which ? done2 : done0;
    s_a    = which ? a2 : a0;
    s_b    = which ? b2 : b0;
    s_ec   = which ? ec2 : ec0;
    s_se   = which ? se2 : se0;
    s_mx   = which ? mx2 : mx0;
    s_wa   = which ? wa2 : wa0;
    s_wb   = which ? wb2 : wb0;
  end

  task automatic check(input string tag, input longint obs,
                       input longint exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int m, input bit lat2);
    exp_t e;
    int p, ap, d;
    e = '{0, 0, 0, 0, 0, 0, 0};
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        p  = a * b;
        ap = (m == 1) ? 0 : (m == 2) ? (p | 1) : p;
        d  = (ap > p) ? ap - p : p - ap;
        if (d != 0) e.err++;
        e.sum += d;
        if (d > e.mx) begin
          e.mx = d; e.wa = a; e.wb = b;
        end
      end
    e.dc = lat2 ? 259 : 257;
    e.bc = lat2 ? 258 : 256;
    return e;
  endfunction

  task automatic check_metrics(input string tag, input exp_t e);
    check({tag, "_err_cnt"}, s_ec, e.err);
    check({tag, "_sum"}, s_se, e.sum);
    check({tag, "_max"}, s_mx, e.mx);
    check({tag, "_worst_a"}, s_wa, e.wa);
    check({tag, "_worst_b"}, s_wb, e.wb);
  endtask

  task automatic run_sweep(input string tag, input bit w,
                           input int m, input bit hold);
    exp_t e;
    int   cyc, bcnt;
    bit   got;
    which = w;
    mode  = m;
    sbq.push_back(model(m, w));
    @(negedge clk);
    if (w) start2 = 1'b1;
    else   start0 = 1'b1;
    @(posedge clk); #1;
    if (!hold) begin
      start0 = 1'b0;
      start2 = 1'b0;
    end
    cyc  = 1;
    bcnt = 0;
    got  = 1'b0;
    check({tag, "_first_op"}, {s_a, s_b}, 0);
    while (!got && cyc < 400) begin
      if (s_busy) bcnt++;
      if (s_done) got = 1'b1;
      else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    e = sbq.pop_front();
    check({tag, "_done_seen"}, got, 1);
    check({tag, "_done_cycle"}, cyc, e.dc);
    check({tag, "_busy_cycles"}, bcnt, e.bc);
    check({tag, "_busy_in_done"}, s_busy, 0);
    check_metrics(tag, e);
    @(posedge clk); #1;
    check({tag, "_done_single"}, s_done, 0);
    check({tag, "_idle_busy"}, s_busy, 0);
    check_metrics({tag, "_hold"}, e);
  endtask

  initial begin
    int dn;
    bit hit;
    rst    = 1'b1;
    start0 = 1'b0;
    start2 = 1'b0;
    mode   = 0;
    which  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_ops", {a0, b0}, 0);
    check("rst_err_cnt", ec0, 0);
    check("rst_sum", se0, 0);
    check("rst_max", mx0, 0);
    check("rst_worst", {wa0, wb0}, 0);
    check("rst_busy2", busy2, 0);
    @(negedge clk);
    rst = 1'b0;

    run_sweep("exact", 1'b0, 0, 1'b0);
    run_sweep("zero", 1'b0, 1, 1'b0);
    run_sweep("or1", 1'b0, 2, 1'b0);
    run_sweep("lat2", 1'b1, 0, 1'b0);

    // abort a sweep at pair 100 with rst
    which = 1'b0;
    mode  = 1;
    @(negedge clk);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 300 && !hit; c++) begin
      if ({a0, b0} == 8'd100) hit = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("abort_pair100_seen", hit, 1);
    check("abort_pre_err_nz", (ec0 != 0), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    check("abort_ops", {a0, b0}, 0);
    check("abort_err_cnt", ec0, 0);
    check("abort_sum", se0, 0);
    check("abort_max", mx0, 0);
    check("abort_worst", {wa0, wb0}, 0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep("post_abort", 1'b0, 0, 1'b0);

    // start held high: one sweep, then a restart from IDLE
    run_sweep("held", 1'b0, 1, 1'b1);
    @(posedge clk); #1;
    check("held_restart_busy", busy0, 1);
    start0 = 1'b0;
    mode   = 0;
    dn     = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (done0) dn++;
    end
    check("held_second_done_cnt", dn, 1);
    check("held_final_busy", busy0, 0);
    check("held_final_err_cnt", ec0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached before summary");
    $fatal(1, "timeout");
  end

endmodule
